// File: rtl/imem_pkg.sv
// Shared types for the instruction-memory loader.
// Define IMEM_LOADER_CHECKSUM_EN to add the trailing-checksum CHECK state.
package imem_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_CHECK, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;
`endif
endpackage

// File: rtl/imem_word_assembler.sv
// Big-endian byte-to-word shift register; word_full flags the byte that completes a word.
module imem_word_assembler
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);
  logic [WORD_W-1:0] sr;
  logic [1:0]        cnt;

  // word is the value the register takes if byte_in is shifted in this cycle
  assign word      = {sr[WORD_W-9:0], byte_in};
  assign word_full = shift_en && (cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clear) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      sr  <= word;
      cnt <= cnt + 2'd1;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Streams a program into instruction memory, holding the CPU while the image is written.
// Optional trailing checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [31:0]       wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam logic [ADDR_W:0] MAX_WC = (ADDR_W+1)'(MAX_WORDS);

  state_t            state, state_nx;
  logic [ADDR_W:0]   index, index_inc, count;
  logic              accept, shift_en, word_full, csum_bad;
  logic [WORD_W-1:0] word;

  assign index_inc = index + 1'b1;
  assign shift_en  = (state == S_LOAD) && byte_valid;
  assign wr_en     = (state == S_WRITE);
  assign done      = (state == S_DONE);
  assign busy      = !(state == S_IDLE || state == S_DONE);
  assign cpu_hold  = busy;

  imem_word_assembler u_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (accept),
    .shift_en (shift_en),
    .byte_in  (byte_in),
    .word     (word),
    .word_full(word_full)
  );

  always_comb begin
    state_nx   = state;
    byte_ready = 1'b0;
    accept     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept = 1'b1;
          if (word_count == '0 || word_count > MAX_WC) state_nx = S_DONE;
          else                                         state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        byte_ready = 1'b1;
        if (word_full) state_nx = S_WRITE;
      end
      S_WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        state_nx = (index_inc == count) ? S_CHECK : S_LOAD;
`else
        state_nx = (index_inc == count) ? S_DONE : S_LOAD;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nx = S_DONE;
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        csum <= '0;
    else if (accept)   csum <= '0;
    else if (shift_en) csum <= csum ^ byte_in;
  end
  assign csum_bad = (state == S_CHECK) && byte_valid && (byte_in != csum);
`else
  assign csum_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      index   <= '0;
      count   <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      error   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        count <= word_count;
        index <= '0;
        error <= (word_count > MAX_WC);
      end else if (csum_bad) begin
        error <= 1'b1;
      end
      // Latch address/data as the word completes so they hold steady outside WRITE
      if (word_full) begin
        wr_data <= word;
        wr_addr <= BASE_ADDR + 32'({index, 2'b00});
      end
      if (state == S_WRITE) index <= index_inc;
    end
  end
endmodule
